// File: rtl/ysyx_040066_mul_ctrl.sv
// Issue/retire controller for the two-stage Booth-Wallace multiplier.
// Latency: a request accepted at edge n is presented to writeback after edge n+1 (2 cycles).
// Backpressure: out_ready low with a result pending freezes both stages and drops in_ready combinationally.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   flush               synchronous kill of all in-flight operations
//   in_valid/in_ready   request handshake; in_src1/in_src2/in_aluctr/in_is_w/in_tag carry the op
//   mul_block           freezes the multiplier (both stages)
//   mul_src*_in, mul_aluctr_in   stage-0 operands/op, combinational pass-through
//   mul_aluctr, mul_is_w         stage-1 op controls, registered
//   mul_result          multiplier output, valid in the cycle after its stage-1 edge
//   out_valid/out_ready result handshake; out_result/out_tag gated to 0 when idle
//   busy                any stage holds a live operation
module ysyx_040066_mul_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_src1,
  input  logic [63:0]      in_src2,
  input  logic [1:0]       in_aluctr,
  input  logic             in_is_w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_block,
  output logic [63:0]      mul_src1_in,
  output logic [63:0]      mul_src2_in,
  output logic [1:0]       mul_aluctr_in,
  output logic [1:0]       mul_aluctr,
  output logic             mul_is_w,
  input  logic [63:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // Stage 1: op sits in the multiplier's first pipeline register.
  logic             s1_valid;
  logic [1:0]       s1_aluctr;
  logic             s1_is_w;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2: result is on mul_result and presented to writeback.
  logic             s2_valid;
  logic [TAG_W-1:0] s2_tag;

  // Only a live, unaccepted result can stall; an empty s2 never blocks,
  // so bubbles in s1 always advance.
  assign mul_block = s2_valid & ~out_ready;
  assign in_ready  = ~mul_block;

  // The multiplier samples stage-0 inputs on every unblocked edge; bubbles
  // are tracked here through s1_valid rather than by gating the operands.
  assign mul_src1_in   = in_src1;
  assign mul_src2_in   = in_src2;
  assign mul_aluctr_in = in_aluctr;

  assign mul_aluctr = s1_aluctr;
  assign mul_is_w   = s1_is_w;

  assign out_valid  = s2_valid;
  assign out_result = s2_valid ? mul_result : 64'd0;
  assign out_tag    = s2_valid ? s2_tag : '0;
  assign busy       = s1_valid | s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_aluctr <= 2'b00;
      s1_is_w   <= 1'b0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_tag    <= '0;
    end else if (flush) begin
      // Kill wins over accept and hold; the data fields are don't-care
      // once the valids are clear, so they simply keep their values.
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (!mul_block) begin
      s1_valid  <= in_valid;
      s1_aluctr <= in_aluctr;
      s1_is_w   <= in_is_w;
      s1_tag    <= in_tag;
      s2_valid  <= s1_valid;
      s2_tag    <= s1_tag;
    end
  end

endmodule

// File: doc/ysyx_040066_mul_ctrl.md
# ysyx_040066_mul_ctrl

Issue/retire controller for the two-stage Booth–Wallace multiplier in the execute stage of the ysyx_040066 core. It accepts multiply requests from the EX issue logic over a valid/ready handshake and drives the multiplier's stage-0/stage-1 control inputs. It tracks per-stage valid and tag state, exposes the result to writeback over a second valid/ready handshake, and freezes the multiplier through `block` whenever writeback back-pressures.

## Interface
Parameters:
- TAG_W, default 5: width of the destination tag (rd index) carried alongside each operation.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when `in_valid & in_ready` at a rising edge.
- in_src1, in_src2  in  64  operands.
- in_aluctr  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_is_w  in  1  32-bit (W) form; only meaningful with aluctr 00.
- in_tag  in  TAG_W  destination tag.
- mul_block  out  1  to multiplier `block`.
- mul_src1_in, mul_src2_in  out  64  to multiplier stage-0 operands.
- mul_aluctr_in  out  2  to multiplier stage-0 op.
- mul_aluctr  out  2  to multiplier stage-1 op.
- mul_is_w  out  1  to multiplier stage-1 W flag.
- mul_result  in  64  multiplier result, valid in the cycle after its stage-1 edge.
- out_valid  out  1  result valid to writeback.
- out_ready  in  1  writeback accepts the result.
- out_result  out  64  result; forced to 0 when `out_valid=0`.
- out_tag  out  TAG_W  tag of the presented result; 0 when `out_valid=0`.
- busy  out  1  `s1_valid | s2_valid`.

## Operation
- State registers: `s1_valid`, `s1_aluctr[1:0]`, `s1_is_w`, `s1_tag`; `s2_valid`, `s2_tag`. All of them reset to 0.
- Stall: `mul_block = s2_valid & ~out_ready`. `in_ready = ~mul_block`.
- Operand path: `mul_src1_in/mul_src2_in/mul_aluctr_in` are driven combinationally from `in_src1/in_src2/in_aluctr`. The multiplier samples them on any unblocked edge. Data sampled while `in_valid=0` becomes a bubble and is ignored through `s1_valid=0`.
- Stage-1 controls: `mul_aluctr = s1_aluctr`, `mul_is_w = s1_is_w`, both driven from registers.
- Advance on an edge with `~mul_block`:
  - `s1_valid <= in_valid`; s1 fields load from the inputs.
  - `s2_valid <= s1_valid`; `s2_tag <= s1_tag`.
- Hold: when `mul_block=1`, all s1/s2 registers hold.
- Flush: on an edge with `flush=1`, `s1_valid` and `s2_valid` clear regardless of block, and the concurrent request is not accepted (`in_ready` still reads as computed, but no state loads). Flush has priority over accept and hold.
- Output: `out_valid = s2_valid`; `out_result = s2_valid ? mul_result : 0`; `out_tag` is gated the same way.
- Bubbles collapse nowhere. An empty s2 never blocks, so a bubble in s1 simply advances.
- Reset mid-operation clears all valids asynchronously. The multiplier's internal data registers have no reset; their contents are don't-care because the valids are 0.
- Width and sign rules are the multiplier's. The controller passes them through unmodified:
  - MUL returns the low 64 bits.
  - MUL with `is_w` returns the low 32 bits sign-extended.
  - MULH/MULHSU/MULHU return bits [127:64] with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.

## Timing
- Latency: a request accepted at edge n is presented on `out_valid` in the cycle following edge n+1, i.e. 2 cycles.
- Throughput: 1 operation per cycle with `out_ready=1`.
- Back-pressure is combinational: `out_ready` falling immediately drops `in_ready` and asserts `mul_block` in the same cycle. There are no extra bubbles on release.
- An output handshake and an input accept on the same edge are both legal.
- At most two operations are ever in flight. No skid buffer is needed because block freezes both stages.
- Reset values: `in_ready=1`, `mul_block=0`, `out_valid=0`, `out_result=0`, `out_tag=0`, `busy=0`, `mul_aluctr=0`, `mul_is_w=0`.

## Test plan
- Single MUL: in_src1=3, in_src2=5, ctr=00, tag=7, out_ready=1. Required: `out_valid` in the cycle after edge n+1, with out_result=15 and out_tag=7, then idle with busy=0.
- High forms:
  - MULHU with 0xFFFF_FFFF_FFFF_FFFF squared gives 0xFFFF_FFFF_FFFF_FFFE.
  - MULH of -1×-1 gives 0.
  - MULHSU of -1×2 gives 0xFFFF_FFFF_FFFF_FFFF.
- W form: MUL with is_w=1, 0x7FFF_FFFF×2 gives 0xFFFF_FFFF_FFFF_FFFE.
- Back-to-back with stall: issue tags 1, 2, 3 on consecutive cycles and hold out_ready=0 for 2 cycles once tag 1 is presented. Required: in_ready=0 and tag 1 stable during the stall; results retire in order 1, 2, 3 with correct values; no loss or duplication.
- Flush: issue two ops, then assert flush with a third request on the same edge. Required: the next cycle has out_valid=0 and busy=0, and the third op is never produced.
- Async reset: assert rst mid-cycle with two ops in flight. Required: out_valid, busy and out_result go to 0 immediately. After release, a fresh 6×7 returns 42.
